// File: rtl/instr_mem_loader.sv
// Framed byte stream -> 16-bit instruction memory writes, CPU held in stall for the whole load.
// Define LOADER_CSUM_EN to require a trailing 8-bit checksum byte (payload sum + checksum == 0).
module instr_mem_loader #(
  parameter int PROG_CTR_WID = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    wr_en,
  output logic [PROG_CTR_WID-1:0] wr_addr,
  output logic [15:0]             wr_data,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state;
  logic [15:0]             len;
  logic [7:0]              hi_byte;
  logic [PROG_CTR_WID-1:0] addr;
`ifdef LOADER_CSUM_EN
  logic [7:0]              csum;
`endif

  logic        accept;
  logic [15:0] len_nxt;
  logic        len_ok;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign len_nxt   = {len[15:8], byte_in};
  // Upper bound keeps the highest written address inside the memory, so addr never wraps.
  assign len_ok    = (len_nxt != 16'd0) && ({1'b0, len_nxt} <= (17'd1 << PROG_CTR_WID));
  assign last_word = (17'(addr) + 17'd1) == {1'b0, len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      hi_byte    <= '0;
      addr       <= '0;
`ifdef LOADER_CSUM_EN
      csum       <= '0;
`endif
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN_HI;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            addr       <= '0;
`ifdef LOADER_CSUM_EN
            csum       <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_in;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_in;
            if (len_ok) begin
              state <= S_DATA_HI;
            end else begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
              load_err   <= 1'b1;
            end
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            hi_byte <= byte_in;
`ifdef LOADER_CSUM_EN
            csum    <= csum + byte_in;
`endif
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= {hi_byte, byte_in};
`ifdef LOADER_CSUM_EN
            csum    <= csum + byte_in;
`endif
            if (last_word) begin
`ifdef LOADER_CSUM_EN
              state <= S_CSUM;
`else
              state      <= S_DONE;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
              load_done  <= 1'b1;
`endif
            end else begin
              addr  <= addr + 1'b1;
              state <= S_DATA_HI;
            end
          end
        end
`ifdef LOADER_CSUM_EN
        S_CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            if (8'(csum + byte_in) == 8'h00) begin
              state     <= S_DONE;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule
